// File: rtl/scan_pkg.sv
// Shared types for the serial pattern scan controller: FSM state, termination reasons, length clamp.
package scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ARM  = 4'b0010,
    ST_SCAN = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    RSN_WINDOW = 2'd0,
    RSN_MAX    = 2'd1,
    RSN_ABORT  = 2'd2
  } reason_t;

  // A zero length behaves as a single-bit pattern; oversize lengths use the full pattern.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Bit history, saturating fill depth and masked pattern compare; hit reflects the post-shift history.
module pattern_match_core #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  // Only PAT_W-1 old bits need storing; the newest bit joins them at compare time.
  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-1:0] hist_n;
  logic [LEN_W-1:0] depth_q;
  logic [LEN_W-1:0] depth_n;
  logic [PAT_W:0]   mask_w;
  logic [PAT_W-1:0] mask;

  assign hist_n  = {hist_q, bit_in};
  assign depth_n = (depth_q < len) ? depth_q + LEN_W'(1) : depth_q;
  assign mask_w  = ((PAT_W+1)'(1) << len) - (PAT_W+1)'(1);
  assign mask    = mask_w[PAT_W-1:0];
  assign hit     = shift_en && (depth_n >= len) && ((hist_n & mask) == (pattern & mask));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q  <= '0;
      depth_q <= '0;
    end else if (clear) begin
      hist_q  <= '0;
      depth_q <= '0;
    end else if (shift_en) begin
      hist_q  <= hist_n[PAT_W-2:0];
      depth_q <= depth_n;
    end
  end

endmodule

// File: rtl/serial_pattern_scan_ctrl.sv
// Scan session controller: arms the matcher, accepts bits, counts matches/bits and terminates the session.
module serial_pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic [CNT_W-1:0]             cfg_window,
  input  logic [CNT_W-1:0]             cfg_max_match,
  input  logic                         abort,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic                         match_pulse,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   done_reason,
  output logic [CNT_W-1:0]             match_count,
  output logic [CNT_W-1:0]             bits_seen
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  state_t           state_q, state_n;
  reason_t          reason_q, reason_n;
  logic [PAT_W-1:0] pattern_q, pattern_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [CNT_W-1:0] window_q, window_n;
  logic [CNT_W-1:0] max_q, max_n;
  logic [CNT_W-1:0] match_q, match_n;
  logic [CNT_W-1:0] bits_q, bits_n;
  logic             pulse_q, pulse_n;
  logic             ready_q, busy_q, done_q;
  logic             start_take;
  logic             count_en;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign start_take = (state_q == ST_IDLE) && start;
  // An aborting cycle still consumes the offered bit but never counts or matches it.
  assign count_en   = (state_q == ST_SCAN) && bit_valid && !abort;

  pattern_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (count_en),
    .clear    (start_take),
    .bit_in   (bit_in),
    .pattern  (pattern_q),
    .len      (len_q),
    .hit      (hit)
  );

  // Next-state, counter and termination decode.
  always_comb begin
    state_n   = state_q;
    reason_n  = reason_q;
    pattern_n = pattern_q;
    len_n     = len_q;
    window_n  = window_q;
    max_n     = max_q;
    match_n   = match_q;
    bits_n    = bits_q;
    pulse_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pattern_n = cfg_pattern;
          len_n     = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
          window_n  = cfg_window;
          max_n     = cfg_max_match;
          match_n   = '0;
          bits_n    = '0;
          reason_n  = RSN_WINDOW;
          state_n   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort) begin
          reason_n = RSN_ABORT;
          state_n  = ST_DONE;
        end else begin
          state_n = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          reason_n = RSN_ABORT;
          state_n  = ST_DONE;
        end else if (bit_valid) begin
          bits_n = sat_inc(bits_q);
          if (hit) begin
            match_n = sat_inc(match_q);
            pulse_n = 1'b1;
          end
          if ((max_q != '0) && (match_n == max_q)) begin
            reason_n = RSN_MAX;
            state_n  = ST_DONE;
          end else if ((window_q != '0) && (bits_n == window_q)) begin
            reason_n = RSN_WINDOW;
            state_n  = ST_DONE;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      reason_q  <= RSN_WINDOW;
      pattern_q <= '0;
      len_q     <= '0;
      window_q  <= '0;
      max_q     <= '0;
      match_q   <= '0;
      bits_q    <= '0;
      pulse_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      reason_q  <= reason_n;
      pattern_q <= pattern_n;
      len_q     <= len_n;
      window_q  <= window_n;
      max_q     <= max_n;
      match_q   <= match_n;
      bits_q    <= bits_n;
      pulse_q   <= pulse_n;
      ready_q   <= (state_n == ST_SCAN);
      busy_q    <= (state_n == ST_ARM) || (state_n == ST_SCAN);
      done_q    <= (state_n == ST_DONE);
    end
  end

  assign bit_ready   = ready_q;
  assign match_pulse = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_reason = reason_q;
  assign match_count = match_q;
  assign bits_seen   = bits_q;

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
// Self-checking bench for serial_pattern_scan_ctrl: directed scenarios plus randomized sessions vs a queue-based model.
module tb_serial_pattern_scan_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_window;
  logic [15:0] cfg_max_match;
  logic        abort;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        match_pulse;
  logic        busy;
  logic        done;
  logic [1:0]  done_reason;
  logic [15:0] match_count;
  logic [15:0] bits_seen;

  int total = 0;
  int bad   = 0;

  serial_pattern_scan_ctrl #(.PAT_W(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfg_pattern   (cfg_pattern),
    .cfg_len       (cfg_len),
    .cfg_window    (cfg_window),
    .cfg_max_match (cfg_max_match),
    .abort         (abort),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .match_pulse   (match_pulse),
    .busy          (busy),
    .done          (done),
    .done_reason   (done_reason),
    .match_count   (match_count),
    .bits_seen     (bits_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: does the newest len accepted bits equal pattern[len-1:0] (bit 0 = newest)?
  function automatic bit tail_match(input int q[$], input logic [7:0] pat, input int len);
    if (q.size() < len) return 1'b0;
    for (int i = 0; i < len; i++)
      if (q[q.size()-1-i] != int'(pat[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                          input logic [15:0] win, input logic [15:0] mx);
    cfg_pattern   = pat;
    cfg_len       = len;
    cfg_window    = win;
    cfg_max_match = mx;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bit_ready, match_pulse, busy, done, done_reason, match_count, bits_seen} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h exp 0",
               {bit_ready, match_pulse, busy, done, done_reason, match_count, bits_seen});
    end
    tick();
    rstn = 1'b1;
    tick();
    total++;
    if ({busy, done, bit_ready} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b exp 000", {busy, done, bit_ready});
    end
  endtask

  task automatic test_window();
    logic [4:0] stream;
    stream = 5'b10101;
    do_start(8'b101, 4'd3, 16'd5, 16'd0);
    total++;
    if ({busy, bit_ready, done} !== 3'b100) begin
      bad++;
      $display("FAIL window_arm: got %b exp 100", {busy, bit_ready, done});
    end
    tick();
    total++;
    if (bit_ready !== 1'b1) begin
      bad++;
      $display("FAIL window_ready_latency: got %b exp 1", bit_ready);
    end
    for (int i = 0; i < 5; i++) begin
      send_bit(stream[4-i]);
      total++;
      if (match_pulse !== ((i == 2) || (i == 4))) begin
        bad++;
        $display("FAIL window_pulse bit%0d: got %b exp %b", i + 1, match_pulse, (i == 2) || (i == 4));
      end
    end
    total++;
    if ({done, bit_ready, done_reason, match_count, bits_seen} !== {1'b1, 1'b0, 2'd0, 16'd2, 16'd5}) begin
      bad++;
      $display("FAIL window_end: got %h exp %h", {done, bit_ready, done_reason, match_count, bits_seen},
               {1'b1, 1'b0, 2'd0, 16'd2, 16'd5});
    end
    tick();
    total++;
    if ({done, busy, done_reason, match_count, bits_seen} !== {1'b0, 1'b0, 2'd0, 16'd2, 16'd5}) begin
      bad++;
      $display("FAIL window_hold: got %h exp %h", {done, busy, done_reason, match_count, bits_seen},
               {1'b0, 1'b0, 2'd0, 16'd2, 16'd5});
    end
  endtask

  task automatic test_max_limit();
    logic [4:0] stream;
    stream = 5'b10101;
    do_start(8'b101, 4'd3, 16'd5, 16'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = stream[4-i];
      tick();
      if (i == 2) begin
        total++;
        if ({done, match_pulse, done_reason, match_count, bits_seen} !== {1'b1, 1'b1, 2'd1, 16'd1, 16'd3}) begin
          bad++;
          $display("FAIL max_end: got %h exp %h", {done, match_pulse, done_reason, match_count, bits_seen},
                   {1'b1, 1'b1, 2'd1, 16'd1, 16'd3});
        end
      end
      if (i >= 2) begin
        total++;
        if (bit_ready !== 1'b0) begin
          bad++;
          $display("FAIL max_ready_low cyc%0d: got %b exp 0", i, bit_ready);
        end
      end
    end
    bit_valid = 1'b0;
    total++;
    if ({busy, done_reason, match_count, bits_seen} !== {1'b0, 2'd1, 16'd1, 16'd3}) begin
      bad++;
      $display("FAIL max_hold: got %h exp %h", {busy, done_reason, match_count, bits_seen},
               {1'b0, 2'd1, 16'd1, 16'd3});
    end
  endtask

  task automatic test_abort();
    do_start(8'b101, 4'd3, 16'd0, 16'd0);
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    total++;
    if ({done, match_pulse, done_reason, bits_seen, match_count} !== {1'b1, 1'b0, 2'd2, 16'd2, 16'd0}) begin
      bad++;
      $display("FAIL abort_end: got %h exp %h", {done, match_pulse, done_reason, bits_seen, match_count},
               {1'b1, 1'b0, 2'd2, 16'd2, 16'd0});
    end
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, done_reason} !== {1'b0, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL abort_idle_noeffect: got %b exp 0010", {busy, done, done_reason});
    end
  endtask

  task automatic test_flow_clamp();
    logic [15:0] eb, em;
    logic        v, b, ended;
    eb = 16'd0;
    em = 16'd0;
    ended = 1'b0;
    do_start(8'h01, 4'd0, 16'd6, 16'd0);
    total++;
    if (bit_ready !== 1'b0) begin
      bad++;
      $display("FAIL flow_ready_arm: got %b exp 0", bit_ready);
    end
    tick();
    total++;
    if (bit_ready !== 1'b1) begin
      bad++;
      $display("FAIL flow_ready_2cyc: got %b exp 1", bit_ready);
    end
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      v = ((cyc % 3) == 0);
      b = 1'($urandom % 2);
      bit_valid = v;
      bit_in    = b;
      tick();
      if (v) begin
        eb = eb + 16'd1;
        if (b) em = em + 16'd1;
      end
      ended = v && (eb == 16'd6);
      total++;
      if ({match_pulse, done, match_count, bits_seen} !== {v & b, ended, em, eb}) begin
        bad++;
        $display("FAIL flow_cycle%0d: got %h exp %h", cyc, {match_pulse, done, match_count, bits_seen},
                 {v & b, ended, em, eb});
      end
    end
    bit_valid = 1'b0;
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL flow_timeout: got no done exp done");
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'b101, 4'd3, 16'd0, 16'd0);
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({bit_ready, match_pulse, busy, done, done_reason, match_count, bits_seen} !== 38'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h exp 0",
               {bit_ready, match_pulse, busy, done, done_reason, match_count, bits_seen});
    end
    tick();
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL midreset_nodone: got %b exp 00", {done, busy});
    end
    rstn = 1'b1;
    tick();
    do_start(8'b11, 4'd2, 16'd2, 16'd0);
    tick();
    send_bit(1'b1);
    total++;
    if ({match_count, bits_seen} !== {16'd0, 16'd1}) begin
      bad++;
      $display("FAIL restart_first: got %h exp %h", {match_count, bits_seen}, {16'd0, 16'd1});
    end
    send_bit(1'b1);
    total++;
    if ({done, match_pulse, done_reason, match_count, bits_seen} !== {1'b1, 1'b1, 2'd0, 16'd1, 16'd2}) begin
      bad++;
      $display("FAIL restart_end: got %h exp %h", {done, match_pulse, done_reason, match_count, bits_seen},
               {1'b1, 1'b1, 2'd0, 16'd1, 16'd2});
    end
    tick();
  endtask

  task automatic test_start_ignored();
    do_start(8'b101, 4'd3, 16'd4, 16'd0);
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    cfg_pattern = 8'h00;
    cfg_len     = 4'd1;
    cfg_window  = 16'd2;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    total++;
    if ({busy, bit_ready, match_count, bits_seen} !== {1'b1, 1'b1, 16'd0, 16'd2}) begin
      bad++;
      $display("FAIL start_ignored_counts: got %h exp %h", {busy, bit_ready, match_count, bits_seen},
               {1'b1, 1'b1, 16'd0, 16'd2});
    end
    send_bit(1'b1);
    total++;
    if ({match_pulse, done, match_count, bits_seen} !== {1'b1, 1'b0, 16'd1, 16'd3}) begin
      bad++;
      $display("FAIL start_ignored_match: got %h exp %h", {match_pulse, done, match_count, bits_seen},
               {1'b1, 1'b0, 16'd1, 16'd3});
    end
    send_bit(1'b1);
    total++;
    if ({done, match_pulse, done_reason, match_count, bits_seen} !== {1'b1, 1'b0, 2'd0, 16'd1, 16'd4}) begin
      bad++;
      $display("FAIL start_ignored_end: got %h exp %h", {done, match_pulse, done_reason, match_count, bits_seen},
               {1'b1, 1'b0, 2'd0, 16'd1, 16'd4});
    end
    tick();
  endtask

  task automatic test_random();
    int          hist[$];
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [15:0] win, mx, eb, em;
    logic [1:0]  er;
    int          eff;
    logic        v, b, a, ep, ed, ended;
    for (int s = 0; s < 40; s++) begin
      pat = 8'($urandom);
      len = 4'($urandom_range(0, 15));
      eff = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
      win = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      mx  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
      hist.delete();
      eb = 16'd0;
      em = 16'd0;
      er = 2'd0;
      ended = 1'b0;
      do_start(pat, len, win, mx);
      tick();
      total++;
      if ({busy, bit_ready, done} !== 3'b110) begin
        bad++;
        $display("FAIL rand_scan_entry s%0d: got %b exp 110", s, {busy, bit_ready, done});
      end
      for (int cyc = 0; cyc < 80 && !ended; cyc++) begin
        v = ($urandom % 4) != 0;
        b = 1'($urandom % 2);
        a = (($urandom % 40) == 0) || (cyc == 79);
        bit_valid = v;
        bit_in    = b;
        abort     = a;
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        if (a) begin
          ended = 1'b1;
          total++;
          if ({done, match_pulse, done_reason, match_count, bits_seen} !== {1'b1, 1'b0, 2'd2, em, eb}) begin
            bad++;
            $display("FAIL rand_abort s%0d: got %h exp %h", s,
                     {done, match_pulse, done_reason, match_count, bits_seen}, {1'b1, 1'b0, 2'd2, em, eb});
          end
        end else begin
          ep = 1'b0;
          ed = 1'b0;
          if (v) begin
            hist.push_back(int'(b));
            eb = eb + 16'd1;
            ep = tail_match(hist, pat, eff);
            if (ep) em = em + 16'd1;
            if (mx != 16'd0 && em == mx) begin
              ed = 1'b1;
              er = 2'd1;
            end else if (win != 16'd0 && eb == win) begin
              ed = 1'b1;
              er = 2'd0;
            end
          end
          total++;
          if ({match_pulse, done, bit_ready, match_count, bits_seen} !== {ep, ed, !ed, em, eb}) begin
            bad++;
            $display("FAIL rand_cycle s%0d c%0d: got %h exp %h", s, cyc,
                     {match_pulse, done, bit_ready, match_count, bits_seen}, {ep, ed, !ed, em, eb});
          end
          if (ed) begin
            ended = 1'b1;
            total++;
            if (done_reason !== er) begin
              bad++;
              $display("FAIL rand_reason s%0d: got %0d exp %0d", s, done_reason, er);
            end
          end
        end
      end
      tick();
      total++;
      if ({done, busy, bit_ready, match_count, bits_seen} !== {3'b000, em, eb}) begin
        bad++;
        $display("FAIL rand_after s%0d: got %h exp %h", s, {done, busy, bit_ready, match_count, bits_seen},
                 {3'b000, em, eb});
      end
    end
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    cfg_pattern   = 8'h00;
    cfg_len       = 4'd0;
    cfg_window    = 16'd0;
    cfg_max_match = 16'd0;
    abort         = 1'b0;
    bit_in        = 1'b0;
    bit_valid     = 1'b0;
    test_reset();
    test_window();
    test_max_limit();
    test_abort();
    test_flow_clamp();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
